// File: rtl/dout_arb_pkg.sv
// Shared definitions for the dout write arbiter.
//   state_t  : arbiter FSM states (IDLE = fixed/starvation priority, BURST = locked owner)
//   owner_w  : width of the owner index for a given requester count, never below 1
package dout_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int owner_w(input int n);
    if ($clog2(n) < 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/dout_write_arbiter_prio_pick.sv
// One-hot priority picker.
//   in     : request vector
//   onehot : single bit set at the highest (DIR=1) or lowest (DIR=0) set bit of in
//   any    : 1 when any bit of in is set
module prio_pick #(
  parameter int N   = 4,
  parameter bit DIR = 1'b1
) (
  input  logic [N-1:0] in,
  output logic [N-1:0] onehot,
  output logic         any
);

  logic found;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    // Scan from the preferred end; the first set bit wins.
    for (int k = 0; k < N; k++) begin
      if (!found && in[DIR ? (N - 1 - k) : k]) begin
        onehot[DIR ? (N - 1 - k) : k] = 1'b1;
        found = 1'b1;
      end
    end
    any = |in;
  end

endmodule

// File: rtl/dout_write_arbiter.sv
// Arbitrates writes from NREQ valid/ready requesters into one output register.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clr          : zero dout when no write happens this cycle
//   req_valid    : per-requester write request
//   req_data     : requester i data at [i*WIDTH +: WIDTH]
//   req_last     : 1 ends the access, 0 locks the arbiter for more beats
//   req_ready    : one-hot grant (combinational)
//   dout         : arbitrated register
//   dout_valid   : high the cycle after a transfer
//   owner        : index of the last / locked writer
//   busy         : high while a burst holds the lock
// Priority: a requester that has waited STARVE_LIMIT cycles beats the fixed
// highest-index-wins order (lowest starving index first); a burst owner beats both.
module dout_write_arbiter
  import dout_arb_pkg::*;
#(
  parameter  int NREQ         = 4,
  parameter  int WIDTH        = 8,
  parameter  int STARVE_LIMIT = 7,
  localparam int OW           = owner_w(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic [OW-1:0]         owner,
  output logic                  busy
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] ONE   = CW'(1);

  state_t              state, state_nxt;
  logic [CW-1:0]       starve_cnt [NREQ];
  logic [NREQ-1:0]     starving;
  logic [NREQ-1:0]     hi_oh, lo_oh;
  logic                hi_any, lo_any;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     xfer_vec;
  logic                xfer;
  logic [OW-1:0]       xfer_idx;
  logic [WIDTH-1:0]    xfer_data;
  logic                xfer_last;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      starving[i] = req_valid[i] && (starve_cnt[i] == LIMIT);
    end
  end

  prio_pick #(.N(NREQ), .DIR(1'b1)) u_pick_hi (
    .in     (req_valid),
    .onehot (hi_oh),
    .any    (hi_any)
  );

  prio_pick #(.N(NREQ), .DIR(1'b0)) u_pick_lo (
    .in     (starving),
    .onehot (lo_oh),
    .any    (lo_any)
  );

  // Transfer decode: grant is one-hot, so at most one requester transfers.
  always_comb begin
    xfer_vec  = req_valid & grant;
    xfer      = |xfer_vec;
    xfer_idx  = '0;
    xfer_data = '0;
    xfer_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        xfer_idx  = OW'(i);
        xfer_data = req_data[i*WIDTH +: WIDTH];
        xfer_last = req_last[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          grant = lo_any ? lo_oh : (hi_any ? hi_oh : '0);
          if (xfer && !xfer_last) state_nxt = BURST;
        end
        BURST: begin
          grant[owner] = 1'b1;
          if (xfer && xfer_last) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign req_ready = grant;
  assign busy      = (state == BURST);

  // Output register and starvation counters
  always_ff @(posedge clock) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      owner      <= '0;
      for (int i = 0; i < NREQ; i++) starve_cnt[i] <= '0;
    end else begin
      dout_valid <= xfer;
      if (xfer) begin
        dout  <= xfer_data;
        owner <= xfer_idx;
      end else if (clr) begin
        dout <= '0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || xfer_vec[i]) starve_cnt[i] <= '0;
        else if (starve_cnt[i] != LIMIT)  starve_cnt[i] <= starve_cnt[i] + ONE;
      end
    end
  end

endmodule

// File: doc/dout_write_arbiter.md
Name: dout_write_arbiter

Overview:
- Arbitrates write access to one shared output register (`dout`) among NREQ requesters using valid/ready handshakes.
- Priority is fixed: highest index wins, matching last-assignment-wins semantics in a clocked process.
- A starvation guard and multi-cycle burst locking are layered on top of the fixed priority.
- A low-priority synchronous clear (`clr`) zeroes the register only when no write happens in that cycle.
- Sits between several register-update sources and any consumer of a single registered value.

Parameters:
- NREQ, 4: number of requesters (≥2).
- WIDTH, 8: data width of `dout` and each request.
- STARVE_LIMIT, 7: wait cycles after which a pending requester is promoted over fixed priority (≥1).

Ports:
- clock  in  1  rising-edge clock, sole clock.
- reset  in  1  synchronous, active-high reset.
- clr  in  1  request to zero `dout`; lowest priority.
- req_valid  in  NREQ  per-requester write request.
- req_data  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- req_last  in  NREQ  1 = this beat ends the requester's access; 0 = lock for further beats.
- req_ready  out  NREQ  one-hot grant, combinational.
- dout  out  WIDTH  arbitrated register.
- dout_valid  out  1  1 for the cycle after a write transfer.
- owner  out  OW  index of the last/locked writer; OW = max(1, $clog2(NREQ)).
- busy  out  1  1 while in BURST.

Behaviour:
- Reset values (synchronous, active-high, one clock): dout=0, dout_valid=0, owner=0, busy=0, state=IDLE, all starve counters=0.
- req_ready is all-zero while reset is high.
- Reset mid-burst drops the lock immediately, with no completion beat.
- A transfer on requester i happens in a cycle when req_valid[i] and req_ready[i] are both 1.
- At most one transfer per cycle.
- Results of transfer on requester i, at the next edge:
  - dout <= req_data[i]
  - dout_valid <= 1
  - owner <= i
- No transfer in a cycle: dout_valid <= 0.
- Write vs clear priority:
  - clr=1 with no transfer: dout <= 0.
  - clr=1 with a transfer: the transfer wins and clr is ignored for that cycle.
  - clr does not affect the state machine, owner or starve counters.
- State IDLE:
  - Winner selection:
    - If any valid requester has its starve counter == STARVE_LIMIT, the lowest such index wins.
    - Otherwise the highest valid index wins.
  - req_ready is one-hot on the winner; all-zero when no requester is valid.
  - Transfer with req_last=1: stay IDLE.
  - Transfer with req_last=0: go to BURST, lock owner.
- State BURST:
  - req_ready is one-hot on owner, regardless of other requests or starvation.
  - Owner transfer with req_last=1: return to IDLE.
  - Owner with req_valid=0: stall in BURST indefinitely, without a timeout.
- Starve counter per requester i, saturating at STARVE_LIMIT:
  - Cleared when req_valid[i]=0 or requester i transfers.
  - Otherwise increments by 1 each cycle.
  - Counters keep incrementing while another requester holds BURST.
- busy = (state == BURST).
- Boundary rules:
  - All requesters valid with no starvation: requester NREQ-1 wins every cycle.
  - Others reach STARVE_LIMIT and are then served lowest-index-first, one per IDLE cycle.
  - A requester dropping valid before grant loses its accumulated wait.
  - Nothing is buffered; data is sampled only in the transfer cycle.

Decomposition:
- Package dout_arb_pkg holds:
  - state enum {IDLE, BURST}
  - function computing OW from NREQ
- Sub-module prio_pick (parameter N, DIR):
  - one-hot picker for highest or lowest set bit, plus an any-set flag.
  - Instantiated twice: highest-valid and lowest-starving.

Test Plan:
- Reset, then req_valid=4'b0000, clr=0 -> dout=0, dout_valid=0, req_ready=0, owner=0; assert reset mid-BURST -> next cycle busy=0, req_ready=0.
- req_valid=4'b0101, data0=8'h11, data2=8'h22, last=1 -> req_ready=4'b0100; next cycle dout=8'h22, dout_valid=1, owner=2.
- Same-cycle transfer from requester 1 (data 8'hA5) with clr=1 -> dout=8'hA5; following cycle with clr=1 and no valid -> dout=0, dout_valid=0.
- Requester 3 held valid with last=1 every cycle, requester 0 held valid -> requester 0 granted on the cycle its counter reaches 7 (8th wait cycle); requester 3 resumes after.
- Requester 1 beat with last=0 (8'h01) -> busy=1, owner=1; requester 3 valid for 5 cycles -> req_ready stays 4'b0010; requester 1 last=1 (8'h02) -> next cycle busy=0, dout=8'h02; requester 3 granted next.
- Owner drops valid mid-burst for 3 cycles -> no transfers, busy=1, dout held, dout_valid=0.
